// File: rtl/alu_accumulator.sv
// Command sequencer feeding the 16-bit OR/NOR logic units: latch a command, let the units
// settle for one EXEC cycle, capture the selected result into the accumulator and return it with flags.
module alu_accumulator (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  input  logic [15:0] or_result,
  input  logic [15:0] nor_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zero,
  output logic        res_neg,
  output logic        res_err,
  output logic [15:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic [15:0] acc;
  logic [2:0]  op_q;
  logic [15:0] next_acc;
  logic        illegal;

  assign a_out = acc;

  // The logic units see a_out/b_out for the whole EXEC cycle, so their outputs are settled here.
  always_comb begin
    next_acc = acc;
    illegal  = 1'b0;
    case (op_q)
      3'b000:  next_acc = acc;
      3'b001:  next_acc = b_out;
      3'b010:  next_acc = or_result;
      3'b011:  next_acc = nor_result;
      3'b100:  next_acc = 16'h0000;
      default: illegal  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= 16'h0000;
      b_out     <= 16'h0000;
      op_q      <= 3'b000;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= 16'h0000;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      res_err   <= 1'b0;
      op_count  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q      <= cmd_op;
            b_out     <= cmd_data;
            cmd_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          acc       <= next_acc;
          res_data  <= next_acc;
          res_zero  <= (next_acc == 16'h0000);
          res_neg   <= next_acc[15];
          res_err   <= illegal;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + 16'd1;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_accumulator.sv
// Scoreboard bench for alu_accumulator: the driver pushes model results at command acceptance,
// a monitor pops and compares them at each result handshake.
module tb_alu_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [15:0] cmd_data = 16'h0000;
  logic [15:0] a_out, b_out, or_result, nor_result;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        res_zero, res_neg, res_err;
  logic [15:0] op_count;

  alu_accumulator dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .a_out(a_out), .b_out(b_out),
    .or_result(or_result), .nor_result(nor_result), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_zero(res_zero),
    .res_neg(res_neg), .res_err(res_err), .op_count(op_count)
  );

  // Stand-ins for orMod / norMod
  assign or_result  = a_out | b_out;
  assign nor_result = ~(a_out | b_out);

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic        neg;
    logic        err;
    logic [15:0] count;
    int          acc_cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          last_hs = 0;
  bit          seen = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [15:0] m_acc = 16'h0000;
  logic [15:0] m_count = 16'h0000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] model_acc(input logic [2:0] op, input logic [15:0] acc,
                                            input logic [15:0] d);
    case (op)
      3'd1:    return d;
      3'd2:    return acc | d;
      3'd3:    return ~(acc | d);
      3'd4:    return 16'h0000;
      default: return acc;
    endcase
  endfunction

  task automatic send(input logic [2:0] op, input logic [15:0] d);
    int   budget = 60;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    while (!cmd_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    if (cmd_ready) begin
      m_acc     = model_acc(op, m_acc, d);
      e.data    = m_acc;
      e.zero    = (m_acc == 16'h0000);
      e.neg     = m_acc[15];
      e.err     = (op > 3'd4);
      e.count   = m_count;
      e.acc_cyc = cyc + 1;
      sbq.push_back(e);
      m_count   = m_count + 16'd1;
      last_acc  = cyc + 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int budget = 300;
    while (sbq.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain", 32'(sbq.size()), 32'd0);
  endtask

  // Random consumer stalls during the randomized phase
  always @(negedge clk) if (rand_rdy) res_ready = ($urandom_range(0, 3) != 0);

  // Monitor: inputs settle at the falling edge, so sampling #1 later shows what the next rising edge sees.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      seen = 1'b0;
      sbq.delete();
    end else if (res_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        e = sbq[0];
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 32'(cyc + 1), 32'(e.acc_cyc + 2));
        end
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        if (res_ready) begin
          chk("res_zero", 32'(res_zero), 32'(e.zero));
          chk("res_neg", 32'(res_neg), 32'(e.neg));
          chk("res_err", 32'(res_err), 32'(e.err));
          chk("op_count", 32'(op_count), 32'(e.count));
          void'(sbq.pop_front());
          seen    = 1'b0;
          last_hs = cyc + 1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_flags", 32'({res_zero, res_neg, res_err}), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    // LOAD then OR, consumer always ready
    send(3'd1, 16'h0F00);
    send(3'd2, 16'h00F0);
    drain();
    chk("op_count_after_two", 32'(op_count), 32'd2);

    // CLEAR then NOR of zero
    send(3'd4, 16'hBEEF);
    send(3'd3, 16'h0000);
    drain();

    // Stalled consumer with a command waiting behind it
    res_ready = 1'b0;
    send(3'd1, 16'h1234);
    fork
      begin
        repeat (7) @(negedge clk);
        res_ready = 1'b1;
      end
    join_none
    send(3'd2, 16'hFFFF);
    chk("accept_after_handshake", 32'(last_acc), 32'(last_hs + 1));
    drain();

    // Illegal opcode, then a legal one clears the error flag
    send(3'd1, 16'h00AA);
    send(3'd6, 16'h5555);
    send(3'd0, 16'h0000);
    drain();

    // Reset during EXEC discards the pending result
    send(3'd1, 16'h8001);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_exec_a_out", 32'(a_out), 32'd0);
    chk("rst_exec_op_count", 32'(op_count), 32'd0);
    chk("rst_exec_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    m_acc = 16'h0000;
    m_count = 16'h0000;
    @(negedge clk);
    chk("rst_exec_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (4) @(negedge clk);
    chk("rst_exec_no_result", 32'(res_valid), 32'd0);

    // Reset wins over a simultaneous result handshake
    send(3'd1, 16'h0001);
    drain();
    res_ready = 1'b0;
    send(3'd1, 16'h4321);
    b = 20;
    while (!res_valid && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk("stall_res_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("rst_resp_op_count", 32'(op_count), 32'd0);
    chk("rst_resp_res_valid", 32'(res_valid), 32'd0);
    chk("rst_resp_res_data", 32'(res_data), 32'd0);
    rst = 1'b0;
    m_acc = 16'h0000;
    m_count = 16'h0000;

    // Randomized commands with random consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(3'($urandom_range(0, 7)), 16'($urandom));
    end
    rand_rdy = 1'b0;
    @(negedge clk);
    res_ready = 1'b1;
    drain();

    // Counter wrap: preload near the top, then two NOPs
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    @(negedge clk);
    release dut.op_count;
    m_count = 16'hFFFE;
    send(3'd0, 16'h0000);
    send(3'd0, 16'h0000);
    drain();
    chk("op_count_wrap", 32'(op_count), 32'(m_count));
    chk("op_count_wrap_zero", 32'(op_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
